// File: rtl/d_jb_predictor_pkg.sv
//------------------------------------------------------------------------------
// Module  : d_jb_predictor_pkg
// Brief   : Shared opcode/func constants, jump-select and bop encodings, and
//           the counter initialisation helper for the jump/branch predictor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package d_jb_predictor_pkg;

    localparam logic [5:0] c_OP_SPECIAL = 6'b000000;
    localparam logic [5:0] c_OP_REGIMM  = 6'b000001;
    localparam logic [5:0] c_OP_J       = 6'b000010;
    localparam logic [5:0] c_OP_JAL     = 6'b000011;
    localparam logic [5:0] c_OP_BEQ     = 6'b000100;
    localparam logic [5:0] c_OP_BNE     = 6'b000101;
    localparam logic [5:0] c_OP_BLEZ    = 6'b000110;
    localparam logic [5:0] c_OP_BGTZ    = 6'b000111;

    localparam logic [5:0] c_FUNC_JR    = 6'b001000;
    localparam logic [4:0] c_REG_RA     = 5'd31;

    localparam logic [1:0] c_JUMP_NONE   = 2'b00;
    localparam logic [1:0] c_JUMP_DIRECT = 2'b01;
    localparam logic [1:0] c_JUMP_REG    = 2'b10;

    localparam logic [2:0] c_BOP_NONE = 3'b000;
    localparam logic [2:0] c_BOP_BEQ  = 3'b001;
    localparam logic [2:0] c_BOP_BNE  = 3'b010;
    localparam logic [2:0] c_BOP_BLEZ = 3'b011;
    localparam logic [2:0] c_BOP_BGTZ = 3'b100;
    localparam logic [2:0] c_BOP_BLTZ = 3'b101;
    localparam logic [2:0] c_BOP_BGEZ = 3'b110;

    // Weakly-not-taken value for a counter of the given width (1..4 bits)
    function automatic logic [3:0] ctr_init(input int ctr_w);
        return 4'((1 << (ctr_w - 1)) - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/jb_ras.sv
//------------------------------------------------------------------------------
// Module  : jb_ras
// Brief   : Circular return-address stack; a push when full overwrites the
//           oldest entry. Built only when JB_RAS_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifdef JB_RAS_EN
module jb_ras #(
    parameter int RAS_DEPTH = 4,
    parameter int PC_W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic [PC_W-1:0] i_push_data,
    input  logic            i_pop,
    output logic            o_valid,
    output logic [PC_W-1:0] o_top
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] c_FULL = (PTR_W+1)'(RAS_DEPTH);

    logic [PC_W-1:0]  r_stack [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W:0]   r_cnt;
    logic [PTR_W-1:0] w_top_ptr;

    // r_ptr is the next free slot, so the top lives one below it
    assign w_top_ptr = r_ptr - PTR_W'(1);
    assign o_top     = r_stack[w_top_ptr];
    assign o_valid   = (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (i_push) begin
            r_stack[r_ptr] <= i_push_data;
            r_ptr          <= r_ptr + PTR_W'(1);
            if (r_cnt != c_FULL) begin
                r_cnt <= r_cnt + (PTR_W+1)'(1);
            end
        end else if (i_pop && (r_cnt != '0)) begin
            r_ptr <= w_top_ptr;
            r_cnt <= r_cnt - (PTR_W+1)'(1);
        end
    end

endmodule
`endif

`default_nettype wire

// File: rtl/d_jb_predictor.sv
//------------------------------------------------------------------------------
// Module  : d_jb_predictor
// Brief   : Decode-stage jump/branch decoder with a saturating-counter branch
//           history table and optional return-address stack (macro JB_RAS_EN).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module d_jb_predictor
    import d_jb_predictor_pkg::*;
#(
    parameter int IDX_W     = 6,
    parameter int CTR_W     = 2,
    parameter int RAS_DEPTH = 4,
    parameter int PC_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_con_valid,
    input  logic [5:0]       i_con_instru,
    input  logic [5:0]       i_con_func,
    input  logic             i_con_rt,
    input  logic [4:0]       i_con_rs,
    input  logic [PC_W-1:0]  i_con_pc,
    input  logic             i_res_valid,
    input  logic [IDX_W-1:0] i_res_idx,
    input  logic             i_res_taken,
    output logic [1:0]       o_con_jump,
    output logic [2:0]       o_con_bop,
    output logic             o_con_aluPC4,
    output logic             o_con_predict,
    output logic [IDX_W-1:0] o_con_idx,
    output logic             o_ras_valid,
    output logic [PC_W-1:0]  o_ras_target
);

    localparam int               BHT_SIZE   = 1 << IDX_W;
    localparam logic [CTR_W-1:0] c_CTR_INIT = CTR_W'(ctr_init(CTR_W));
    localparam logic [CTR_W-1:0] c_CTR_MAX  = {CTR_W{1'b1}};

    logic [CTR_W-1:0] r_bht [BHT_SIZE];
    logic [1:0]       w_jump;
    logic [2:0]       w_bop;
    logic             w_alu_pc4;
    logic [IDX_W-1:0] w_idx;
    logic [CTR_W-1:0] w_res_ctr;

    always_comb begin
        w_jump    = c_JUMP_NONE;
        w_bop     = c_BOP_NONE;
        w_alu_pc4 = 1'b0;
        case (i_con_instru)
            c_OP_BEQ:    w_bop = c_BOP_BEQ;
            c_OP_BNE:    w_bop = c_BOP_BNE;
            c_OP_BLEZ:   w_bop = c_BOP_BLEZ;
            c_OP_BGTZ:   w_bop = c_BOP_BGTZ;
            c_OP_REGIMM: w_bop = i_con_rt ? c_BOP_BGEZ : c_BOP_BLTZ;
            c_OP_J:      w_jump = c_JUMP_DIRECT;
            c_OP_JAL: begin
                w_jump    = c_JUMP_DIRECT;
                w_alu_pc4 = 1'b1;
            end
            c_OP_SPECIAL: begin
                if (i_con_func == c_FUNC_JR) begin
                    w_jump = c_JUMP_REG;
                end
            end
            default: ;
        endcase
    end

    assign w_idx         = i_con_pc[IDX_W+1:2];
    assign o_con_jump    = w_jump;
    assign o_con_bop     = w_bop;
    assign o_con_aluPC4  = w_alu_pc4;
    assign o_con_idx     = w_idx;
    assign o_con_predict = (w_bop != c_BOP_NONE) ? r_bht[w_idx][CTR_W-1] : 1'b0;

    // No read bypass: decode sees the pre-update counter during a write cycle
    assign w_res_ctr = r_bht[i_res_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_SIZE; i++) begin
                r_bht[i] <= c_CTR_INIT;
            end
        end else if (i_res_valid) begin
            if (i_res_taken) begin
                if (w_res_ctr != c_CTR_MAX) begin
                    r_bht[i_res_idx] <= w_res_ctr + CTR_W'(1);
                end
            end else if (w_res_ctr != '0) begin
                r_bht[i_res_idx] <= w_res_ctr - CTR_W'(1);
            end
        end
    end

`ifdef JB_RAS_EN
    logic w_push;
    logic w_pop;

    assign w_push = i_con_valid && (i_con_instru == c_OP_JAL);
    assign w_pop  = i_con_valid && (i_con_instru == c_OP_SPECIAL) &&
                    (i_con_func == c_FUNC_JR) && (i_con_rs == c_REG_RA);

    jb_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .PC_W      (PC_W)
    ) u_jb_ras (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (i_con_pc + PC_W'(4)),
        .i_pop       (w_pop),
        .o_valid     (o_ras_valid),
        .o_top       (o_ras_target)
    );
`else
    logic w_unused_ras_inputs;

    // Stack inputs have no consumer when the stack is not built
    assign w_unused_ras_inputs = ^{i_con_valid, i_con_rs, i_con_pc};
    assign o_ras_valid         = 1'b0;
    assign o_ras_target        = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_d_jb_predictor.sv
//------------------------------------------------------------------------------
// Module  : tb_d_jb_predictor
// Brief   : Directed self-checking bench for d_jb_predictor (default params).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_d_jb_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_con_valid;
    logic [5:0]  i_con_instru;
    logic [5:0]  i_con_func;
    logic        i_con_rt;
    logic [4:0]  i_con_rs;
    logic [31:0] i_con_pc;
    logic        i_res_valid;
    logic [5:0]  i_res_idx;
    logic        i_res_taken;
    logic [1:0]  o_con_jump;
    logic [2:0]  o_con_bop;
    logic        o_con_aluPC4;
    logic        o_con_predict;
    logic [5:0]  o_con_idx;
    logic        o_ras_valid;
    logic [31:0] o_ras_target;

    int n_checks = 0;
    int n_fail   = 0;

    d_jb_predictor u_dut (
        .clk           (clk),
        .rst           (rst),
        .i_con_valid   (i_con_valid),
        .i_con_instru  (i_con_instru),
        .i_con_func    (i_con_func),
        .i_con_rt      (i_con_rt),
        .i_con_rs      (i_con_rs),
        .i_con_pc      (i_con_pc),
        .i_res_valid   (i_res_valid),
        .i_res_idx     (i_res_idx),
        .i_res_taken   (i_res_taken),
        .o_con_jump    (o_con_jump),
        .o_con_bop     (o_con_bop),
        .o_con_aluPC4  (o_con_aluPC4),
        .o_con_predict (o_con_predict),
        .o_con_idx     (o_con_idx),
        .o_ras_valid   (o_ras_valid),
        .o_ras_target  (o_ras_target)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic rt, input logic [4:0] rs, input logic [31:0] pc);
        i_con_valid  = v;
        i_con_instru = op;
        i_con_func   = fn;
        i_con_rt     = rt;
        i_con_rs     = rs;
        i_con_pc     = pc;
    endtask

    task automatic idle_res();
        i_res_valid = 1'b0;
        i_res_idx   = '0;
        i_res_taken = 1'b0;
    endtask

    task automatic do_reset();
        drive(1'b0, 6'b100011, 6'd0, 1'b0, 5'd0, 32'h0);
        idle_res();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 6'b000100, 6'd0, 1'b0, 5'd0, 32'h40);
        #1;
        n_checks++;
        if (o_ras_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ras_valid: got %0b expected 0", o_ras_valid);
        end
        // Every counter reset to 1 (weakly not taken): sample a spread of indices
        for (int k = 0; k < 64; k += 21) begin
            i_con_pc = 32'(k) << 2;
            #1;
            n_checks++;
            if (o_con_predict !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_predict idx%0d: got %0b expected 0", k, o_con_predict);
            end
        end
    endtask

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rt;
        logic [1:0] jmp;
        logic [2:0] bop;
        logic       pc4;
    } dec_vec_t;

    task automatic test_decode();
        dec_vec_t v [12];
        v[0]  = '{6'b000100, 6'd0,      1'b0, 2'b00, 3'b001, 1'b0};
        v[1]  = '{6'b000101, 6'd0,      1'b0, 2'b00, 3'b010, 1'b0};
        v[2]  = '{6'b000110, 6'd0,      1'b0, 2'b00, 3'b011, 1'b0};
        v[3]  = '{6'b000111, 6'd0,      1'b1, 2'b00, 3'b100, 1'b0};
        v[4]  = '{6'b000001, 6'd0,      1'b0, 2'b00, 3'b101, 1'b0};
        v[5]  = '{6'b000001, 6'd0,      1'b1, 2'b00, 3'b110, 1'b0};
        v[6]  = '{6'b000010, 6'd0,      1'b0, 2'b01, 3'b000, 1'b0};
        v[7]  = '{6'b000011, 6'd0,      1'b0, 2'b01, 3'b000, 1'b1};
        v[8]  = '{6'b000000, 6'b001000, 1'b0, 2'b10, 3'b000, 1'b0};
        v[9]  = '{6'b000000, 6'b100000, 1'b0, 2'b00, 3'b000, 1'b0};
        v[10] = '{6'b000000, 6'b001001, 1'b0, 2'b00, 3'b000, 1'b0};
        v[11] = '{6'b100011, 6'b001000, 1'b1, 2'b00, 3'b000, 1'b0};
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, v[k].op, v[k].fn, v[k].rt, 5'd31, 32'h1000);
            #1;
            n_checks++;
            if ({o_con_jump, o_con_bop, o_con_aluPC4} !== {v[k].jmp, v[k].bop, v[k].pc4}) begin
                n_fail++;
                $display("FAIL decode_vec%0d: got jump=%b bop=%b pc4=%b expected jump=%b bop=%b pc4=%b",
                         k, o_con_jump, o_con_bop, o_con_aluPC4, v[k].jmp, v[k].bop, v[k].pc4);
            end
        end
        drive(1'b0, 6'b000100, 6'd0, 1'b0, 5'd0, 32'h12345678);
        #1;
        n_checks++;
        if (o_con_idx !== 6'd30) begin
            n_fail++;
            $display("FAIL decode_idx: got %0d expected 30", o_con_idx);
        end
    endtask

    task automatic test_update_timing();
        do_reset();
        drive(1'b0, 6'b000100, 6'd0, 1'b0, 5'd0, 32'h14);
        i_res_valid = 1'b1;
        i_res_idx   = 6'd5;
        i_res_taken = 1'b1;
        #1;
        n_checks++;
        if (o_con_predict !== 1'b0) begin
            n_fail++;
            $display("FAIL timing_same_cycle: got %0b expected 0", o_con_predict);
        end
        step();
        idle_res();
        #1;
        n_checks++;
        if (o_con_predict !== 1'b1) begin
            n_fail++;
            $display("FAIL timing_next_cycle: got %0b expected 1", o_con_predict);
        end
    endtask

    task automatic test_saturation();
        // Counter trajectory from 1: 2,3,3,3,2,1,0,0,1,2
        logic [9:0] taken    = 10'b1111000011;
        logic [9:0] exp_pred = 10'b1111100001;
        do_reset();
        drive(1'b0, 6'b000100, 6'd0, 1'b0, 5'd0, 32'h40);
        #1;
        n_checks++;
        if (o_con_predict !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_initial: got %0b expected 0", o_con_predict);
        end
        for (int k = 0; k < 10; k++) begin
            i_res_valid = 1'b1;
            i_res_idx   = 6'd16;
            i_res_taken = taken[9-k];
            step();
            idle_res();
            #1;
            n_checks++;
            if (o_con_predict !== exp_pred[9-k]) begin
                n_fail++;
                $display("FAIL sat_step%0d: got %0b expected %0b", k, o_con_predict, exp_pred[9-k]);
            end
        end
        // Counter is 2 (MSB set) but a jump has bop 0, so no prediction
        i_con_instru = 6'b000010;
        #1;
        n_checks++;
        if (o_con_predict !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_nonbranch: got %0b expected 0", o_con_predict);
        end
    endtask

`ifdef JB_RAS_EN
    task automatic test_ras();
        logic [31:0] exp_pop [4] = '{32'h504, 32'h404, 32'h304, 32'h204};
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 6'b000011, 6'd0, 1'b0, 5'd0, 32'(k) << 8);
            step();
            n_checks++;
            if (o_ras_valid !== 1'b1 || o_ras_target !== ((32'(k) << 8) + 32'h4)) begin
                n_fail++;
                $display("FAIL ras_push%0d: got valid=%b target=%h expected valid=1 target=%h",
                         k, o_ras_valid, o_ras_target, (32'(k) << 8) + 32'h4);
            end
        end
        drive(1'b0, 6'b000011, 6'd0, 1'b0, 5'd0, 32'h600);
        step();
        drive(1'b1, 6'b000000, 6'b001000, 1'b0, 5'd30, 32'h604);
        step();
        n_checks++;
        if (o_ras_target !== 32'h504) begin
            n_fail++;
            $display("FAIL ras_no_op: got target=%h expected 504", o_ras_target);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 6'b000000, 6'b001000, 1'b0, 5'd31, 32'h800);
            #1;
            n_checks++;
            if (o_ras_valid !== 1'b1 || o_ras_target !== exp_pop[k]) begin
                n_fail++;
                $display("FAIL ras_pop%0d: got valid=%b target=%h expected valid=1 target=%h",
                         k, o_ras_valid, o_ras_target, exp_pop[k]);
            end
            step();
        end
        n_checks++;
        if (o_ras_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ras_empty: got valid=%b expected 0", o_ras_valid);
        end
        step();
        drive(1'b1, 6'b000011, 6'd0, 1'b0, 5'd0, 32'h700);
        step();
        drive(1'b0, 6'b000011, 6'd0, 1'b0, 5'd0, 32'h700);
        n_checks++;
        if (o_ras_valid !== 1'b1 || o_ras_target !== 32'h704) begin
            n_fail++;
            $display("FAIL ras_after_underflow: got valid=%b target=%h expected valid=1 target=704",
                     o_ras_valid, o_ras_target);
        end
    endtask
`else
    task automatic test_ras();
        do_reset();
        drive(1'b1, 6'b000011, 6'd0, 1'b0, 5'd0, 32'h100);
        step();
        drive(1'b1, 6'b000000, 6'b001000, 1'b0, 5'd31, 32'h200);
        step();
        drive(1'b0, 6'b100011, 6'd0, 1'b0, 5'd0, 32'h0);
        n_checks++;
        if (o_ras_valid !== 1'b0 || o_ras_target !== 32'h0) begin
            n_fail++;
            $display("FAIL ras_disabled: got valid=%b target=%h expected valid=0 target=0",
                     o_ras_valid, o_ras_target);
        end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 6'b000011, 6'd0, 1'b0, 5'd0, 32'h900 + 32'(k * 16));
            i_res_valid = 1'b1;
            i_res_idx   = 6'd16;
            i_res_taken = 1'b1;
            step();
        end
        // Reset coincides with a push and an update; reset must win
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_res();
        drive(1'b0, 6'b000100, 6'd0, 1'b0, 5'd0, 32'h40);
        #1;
        n_checks++;
        if (o_ras_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ras: got valid=%b expected 0", o_ras_valid);
        end
        n_checks++;
        if (o_con_predict !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ctr: got predict=%b expected 0", o_con_predict);
        end
        i_res_valid = 1'b1;
        i_res_idx   = 6'd16;
        i_res_taken = 1'b1;
        step();
        idle_res();
        #1;
        n_checks++;
        if (o_con_predict !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_ctr_is_one: got predict=%b expected 1", o_con_predict);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 6'd0, 6'd0, 1'b0, 5'd0, 32'h0);
        idle_res();
        test_reset();
        test_decode();
        test_update_timing();
        test_saturation();
        test_ras();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
